fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 23 ++
 rtl/fetch_queue.sv | 110 +++++++++++
 tb/tb_fetch_queue.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch redirect, instruction-memory and decode handshake bundle
interface fetch_queue_if #(
    parameter int N = 64
);
    logic          branch_en;
    logic [N-1:0]  branch_target;
    logic [N-1:0]  imem_addr;
    logic [31:0]   imem_data;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic [N-1:0]  instr_pc;

    modport master (
        input  branch_en, branch_target, imem_data, instr_ready,
        output imem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output branch_en, branch_target, imem_data, instr_ready,
        input  imem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC generator feeding a 2-entry instruction queue; FETCH_PERF_EN adds flush_count
module fetch_queue #(
    parameter int N     = 64,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    fetch_queue_if.master       bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         flush_count
`endif
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [N-1:0]       pc_q, pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        instr_mem_q [DEPTH];
    logic [31:0]        instr_mem_d [DEPTH];
    logic [N-1:0]       pc_mem_q    [DEPTH];
    logic [N-1:0]       pc_mem_d    [DEPTH];

    logic full;
    logic pop;
    logic push;
    logic unused_tgt_bits;

    assign unused_tgt_bits = ^bus.branch_target[1:0];

    assign full = (count_q == CNT_W'(DEPTH));
    assign pop  = (count_q != '0) && bus.instr_ready;
    assign push = !bus.branch_en && (!full || pop);

    always_comb begin
        pc_d        = pc_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        if (bus.branch_en) begin
            // Flush beats any concurrent pop; the redirect target is fetched next edge.
            pc_d     = {bus.branch_target[N-1:2], 2'b00};
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                instr_mem_d[wr_ptr_q] = bus.imem_data;
                pc_mem_d[wr_ptr_q]    = pc_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
                pc_d                  = pc_q + N'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
        end
    end

    // Head comes straight from storage: no imem_data bypass into instr.
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = instr_mem_q[rd_ptr_q];
    assign bus.instr_pc    = pc_mem_q[rd_ptr_q];

`ifdef FETCH_PERF_EN
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        flush_count_d = flush_count_q;
        if (bus.branch_en && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_count_q <= '0;
        end else begin
            flush_count_q <= flush_count_d;
        end
    end

    assign flush_count = flush_count_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    fetch_queue_if #(.N(64)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] flush_count;
`endif

    fetch_queue #(.N(64), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .flush_count (flush_count)
`endif
    );

    assign bus.imem_data = 32'h8B00_0000 + bus.imem_addr[31:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        br;
        logic [63:0] tgt;
        logic        rdy;
        logic        exp_valid;
        logic [63:0] exp_pc;
        logic [63:0] exp_addr;
    } vec_t;

    vec_t        vecs [14];
    logic [63:0] sb [$];

    function automatic logic [31:0] exp_instr(input logic [63:0] pc);
        return 32'h8B00_0000 + pc[31:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0;
        bus.branch_en = 1'b0;
        bus.branch_target = '0;
        bus.instr_ready = 1'b0;

        // br, tgt, rdy, exp_valid, exp_pc, exp_addr (outputs after the edge)
        vecs[0]  = '{1'b0, 64'h0,    1'b0, 1'b1, 64'h0,    64'h4};
        vecs[1]  = '{1'b0, 64'h0,    1'b0, 1'b1, 64'h0,    64'h8};
        vecs[2]  = '{1'b0, 64'h0,    1'b0, 1'b1, 64'h0,    64'h8};
        vecs[3]  = '{1'b0, 64'h0,    1'b0, 1'b1, 64'h0,    64'h8};
        vecs[4]  = '{1'b0, 64'h0,    1'b0, 1'b1, 64'h0,    64'h8};
        vecs[5]  = '{1'b0, 64'h0,    1'b1, 1'b1, 64'h4,    64'hC};
        vecs[6]  = '{1'b0, 64'h0,    1'b1, 1'b1, 64'h8,    64'h10};
        vecs[7]  = '{1'b1, 64'h1003, 1'b1, 1'b0, 64'h0,    64'h1000};
        vecs[8]  = '{1'b0, 64'h0,    1'b1, 1'b1, 64'h1000, 64'h1004};
        vecs[9]  = '{1'b0, 64'h0,    1'b1, 1'b1, 64'h1004, 64'h1008};
        vecs[10] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC};
        vecs[11] = '{1'b0, 64'h0,    1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
        vecs[12] = '{1'b0, 64'h0,    1'b1, 1'b1, 64'h0,    64'h4};
        vecs[13] = '{1'b0, 64'h0,    1'b0, 1'b1, 64'h0,    64'h8};

        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", 64'(bus.instr_valid), 64'h0);
        chk("reset addr", bus.imem_addr, 64'h0);
`ifdef FETCH_PERF_EN
        chk("reset flush_count", 64'(flush_count), 64'h0);
`endif
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            bus.branch_en     = vecs[i].br;
            bus.branch_target = vecs[i].tgt;
            bus.instr_ready   = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid", i), 64'(bus.instr_valid), 64'(vecs[i].exp_valid));
            chk($sformatf("v%0d addr", i), bus.imem_addr, vecs[i].exp_addr);
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d pc", i), bus.instr_pc, vecs[i].exp_pc);
                chk($sformatf("v%0d instr", i), 64'(bus.instr), 64'(exp_instr(vecs[i].exp_pc)));
            end
        end
        bus.branch_en = 1'b0;

        // Asynchronous reset between edges with two entries queued.
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset valid", 64'(bus.instr_valid), 64'h0);
        chk("midreset addr", bus.imem_addr, 64'h0);
        #2;
        reset = 1'b1;
        bus.instr_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("postreset valid", 64'(bus.instr_valid), 64'h1);
        chk("postreset pc", bus.instr_pc, 64'h0);
        chk("postreset addr", bus.imem_addr, 64'h4);

        // Streaming with ready held high: scoreboard of expected PCs.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sb.push_back(64'(i) * 64'd4);
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d valid", i), 64'(bus.instr_valid), 64'h1);
            if (bus.instr_valid && sb.size() > 0) begin
                logic [63:0] exp_pc;
                exp_pc = sb.pop_front();
                chk($sformatf("stream%0d pc", i), bus.instr_pc, exp_pc);
                chk($sformatf("stream%0d instr", i), 64'(bus.instr), 64'(exp_instr(exp_pc)));
            end
        end
        chk("stream leftover", 64'(sb.size()), 64'h0);

`ifdef FETCH_PERF_EN
        for (int i = 0; i < 3; i++) begin
            bus.branch_en     = 1'b1;
            bus.branch_target = 64'h2000;
            @(posedge clk);
            #1;
        end
        bus.branch_en = 1'b0;
        chk("flush_count", 64'(flush_count), 64'h3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
